// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the multiplexed hex display controller.
// Build option: HEX_SCAN_BLINK_EN adds per-digit blinking.
package hex_scan_pkg;

  typedef enum logic {
    DRIVE = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       blink;
  } digit_t;

  localparam logic [0:6] SEG_OFF     = 7'b1111111;
  localparam digit_t     DIGIT_RESET = '{value: 4'h0, blank: 1'b1, blink: 1'b0};

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Processor write port of the hex display controller.
// Build option: HEX_SCAN_BLINK_EN (wr_blink is only honoured with it).
interface hex_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();
  localparam int IDX_W = $clog2(NUM_DIGITS);

  // A write transfers on a rising edge where wr_valid && wr_ready; the master
  // holds wr_idx/wr_data/wr_blank/wr_blink stable while wr_valid is high and
  // not yet accepted, and wr_ready does not depend on wr_valid.
  logic             wr_valid;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_data;
  logic             wr_blank;
  logic             wr_blink;

  modport master (
    output wr_valid, wr_idx, wr_data, wr_blank, wr_blink,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_idx, wr_data, wr_blank, wr_blink,
    output wr_ready
  );
endinterface

// File: rtl/hex_seg_decode.sv
// Hex nibble to active-low 7-segment glyph, segments ordered a..g in [0:6].
// Build option: HEX_SCAN_BLINK_EN does not affect this file.
module hex_seg_decode
  import hex_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
    endcase
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Scans a double-buffered bank of hex digits onto a shared active-low segment bus.
// Build option: define HEX_SCAN_BLINK_EN to enable per-digit blinking.
module hex_scan_ctrl
  import hex_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  hex_scan_ctrl_if.slave        wr,
  output logic [0:6]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick,
  output scan_state_t           dbg_state
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = '1;
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      d_q, d_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  digit_t                shadow_q [NUM_DIGITS];
  digit_t                shadow_d [NUM_DIGITS];
  digit_t                active_q [NUM_DIGITS];
  digit_t                active_d [NUM_DIGITS];
  logic [0:6]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  wr_ready_q, wr_ready_d;
  digit_t                cur_entry;
  logic [0:6]            glyph;
  logic                  dark;
  logic                  lit;

`ifdef HEX_SCAN_BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            phase_q, phase_d;
`else
  logic unused_blink;
  assign unused_blink = &{1'b0, wr.wr_blink, cur_entry.blink, 1'(BLINK_FRAMES)};
`endif

  hex_seg_decode u_dec (
    .hex (cur_entry.value),
    .seg (glyph)
  );

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    // d advances on leaving DRIVE, so BLANK with d==0 and cnt==0 is the frame's last cycle
    case (state_q)
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = BLANK;
          cnt_d   = CNT_W'(BLANK_CYCLES - 1);
          d_d     = (d_q == LAST_IDX) ? '0 : d_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BLANK: begin
        if (cnt_q == '0) begin
          state_d = DRIVE;
          cnt_d   = CNT_W'(DWELL_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase

    frame_tick_d = (state_d == BLANK) && (cnt_d == '0) && (d_d == '0);
    wr_ready_d   = !frame_tick_d;

    shadow_d = shadow_q;
    if (wr.wr_valid && wr_ready_q && (int'(wr.wr_idx) < NUM_DIGITS)) begin
      shadow_d[wr.wr_idx].value = wr.wr_data;
      shadow_d[wr.wr_idx].blank = wr.wr_blank;
`ifdef HEX_SCAN_BLINK_EN
      shadow_d[wr.wr_idx].blink = wr.wr_blink;
`else
      shadow_d[wr.wr_idx].blink = 1'b0;
`endif
    end

    active_d = active_q;
    if (frame_tick_q) active_d = shadow_q;

`ifdef HEX_SCAN_BLINK_EN
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (frame_tick_q) begin
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = !phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
`endif

    // Outputs are computed from the next state so the pins line up with state_q
    cur_entry = active_d[d_d];
`ifdef HEX_SCAN_BLINK_EN
    dark = cur_entry.blank | (cur_entry.blink & phase_d);
`else
    dark = cur_entry.blank;
`endif
    lit   = (state_d == DRIVE) && !dark;
    an_d  = lit ? ~(AN_ONE << d_d) : AN_OFF;
    seg_d = lit ? glyph : SEG_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BLANK;
      d_q          <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= DIGIT_RESET;
        active_q[i] <= DIGIT_RESET;
      end
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
      wr_ready_q   <= 1'b0;
`ifdef HEX_SCAN_BLINK_EN
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      d_q          <= d_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
      wr_ready_q   <= wr_ready_d;
`ifdef HEX_SCAN_BLINK_EN
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
`endif
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_tick  = frame_tick_q;
  assign wr.wr_ready = wr_ready_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl: frame-position reference model feeding a scoreboard.
// Build option: HEX_SCAN_BLINK_EN also exercises blinking.
module tb_hex_scan_ctrl;
  import hex_scan_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int BF    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = N * SLOT;
  localparam int W     = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [0:6]    seg;
  logic [N-1:0]  an;
  logic          frame_tick;
  scan_state_t   dbg_state;

  hex_scan_ctrl_if #(.NUM_DIGITS(N)) wr_if ();

  hex_scan_ctrl #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr_if.slave),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int   t;
  int   sh_val [N];
  int   sh_blank [N];
  int   sh_blink [N];
  int   ac_val [N];
  int   ac_blank [N];
  int   ac_blink [N];
  bit   ready_cur;
  bit   tick_cur;
  int   fcnt;
  bit   phase;

  logic [W-1:0] exp_q [$];
  int n_cmp  = 0;
  int n_fail = 0;

  // Cycle t (t>=1 after release) sits at position (t-1) mod FRAME of a frame:
  // each digit owns DW lit cycles then BL dark cycles; the last position commits.
  always @(posedge clk) begin
    int p, k, slot;
    bit lit_e;
    logic [N-1:0] an_e;
    logic [6:0] seg_e;
    if (rst) begin
      t = 0;
      for (int i = 0; i < N; i++) begin
        sh_val[i] = 0; sh_blank[i] = 1; sh_blink[i] = 0;
        ac_val[i] = 0; ac_blank[i] = 1; ac_blink[i] = 0;
      end
      ready_cur = 1'b0;
      tick_cur  = 1'b0;
      fcnt      = 0;
      phase     = 1'b0;
      exp_q.push_back({1'b0, 1'b0, {N{1'b1}}, 7'b1111111});
    end else begin
      if (wr_if.wr_valid && ready_cur && int'(wr_if.wr_idx) < N) begin
        sh_val[wr_if.wr_idx]   = int'(wr_if.wr_data);
        sh_blank[wr_if.wr_idx] = int'(wr_if.wr_blank);
        sh_blink[wr_if.wr_idx] = int'(wr_if.wr_blink);
      end
      if (tick_cur) begin
        ac_val   = sh_val;
        ac_blank = sh_blank;
        ac_blink = sh_blink;
        fcnt++;
        if (fcnt == BF) begin
          fcnt  = 0;
          phase = !phase;
        end
      end
      t++;
      p         = (t - 1) % FRAME;
      k         = p / SLOT;
      slot      = p % SLOT;
      ready_cur = (p != FRAME - 1);
      tick_cur  = (p == FRAME - 1);
      lit_e     = (slot < DW) && (ac_blank[k] == 0);
`ifdef HEX_SCAN_BLINK_EN
      if (ac_blink[k] != 0 && phase) lit_e = 1'b0;
`endif
      an_e  = lit_e ? ~(N'(1) << k) : {N{1'b1}};
      seg_e = lit_e ? glyph_tab[ac_val[k]] : 7'b1111111;
      exp_q.push_back({tick_cur, ready_cur, an_e, seg_e});
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e, got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {frame_tick, wr_if.wr_ready, an, seg};
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL scan t=%0d: got tick=%b rdy=%b an=%b seg=%b, want tick=%b rdy=%b an=%b seg=%b",
                 t, got[12], got[11], got[10:7], got[6:0], e[12], e[11], e[10:7], e[6:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_write(input int idx, input int data, input bit blank, input bit blink);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_idx   = 2'(idx);
    wr_if.wr_data  = 4'(data);
    wr_if.wr_blank = blank;
    wr_if.wr_blink = blink;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (wr_if.wr_ready) begin
        cyc(1);
        wr_if.wr_valid = 1'b0;
        return;
      end
      cyc(1);
    end
    n_cmp++;
    n_fail++;
    $display("FAIL write_timeout: idx=%0d not accepted, want accept within %0d cycles", idx, 3 * FRAME);
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic wait_pos(input int pos);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (t >= 1 && ((t - 1) % FRAME) == pos) return;
      cyc(1);
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_pos: frame position %0d not seen, got t=%0d", pos, t);
  endtask

  task automatic check_reset_now(input string tag);
    n_cmp++;
    if (an !== {N{1'b1}} || seg !== 7'b1111111 || frame_tick !== 1'b0 || wr_if.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%b tick=%b rdy=%b, want an=1111 seg=1111111 tick=0 rdy=0",
               tag, an, seg, frame_tick, wr_if.wr_ready);
    end
  endtask

  task automatic random_writes(input int n);
    for (int i = 0; i < n; i++) begin
      do_write($urandom_range(0, N - 1), $urandom_range(0, 15),
               ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      cyc($urandom_range(0, 5));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_idx   = '0;
    wr_if.wr_data  = '0;
    wr_if.wr_blank = 1'b0;
    wr_if.wr_blink = 1'b0;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;

    // Digits 1,A,8,F land in the shadow before the first commit
    do_write(0, 4'h1, 1'b0, 1'b0);
    do_write(1, 4'hA, 1'b0, 1'b0);
    do_write(2, 4'h8, 1'b0, 1'b0);
    do_write(3, 4'hF, 1'b0, 1'b0);
    wait_pos(0);
    cyc(FRAME / 2);

    // Digit 2 dark, then a write held across the commit cycle
    do_write(2, 4'h3, 1'b1, 1'b0);
    wait_pos(FRAME - 1);
    do_write(1, 4'h5, 1'b0, 1'b0);
    cyc(2 * FRAME);

    random_writes(40);
    cyc(FRAME);

    // Asynchronous reset in the middle of digit 1's lit slot
    wait_pos(SLOT + 1);
    rst = 1'b1;
    #1;
    check_reset_now("async_reset");
    cyc(3);
    check_reset_now("reset_hold");
    rst = 1'b0;
    cyc(2 * FRAME);

    random_writes(20);
    cyc(2 * FRAME);

`ifdef HEX_SCAN_BLINK_EN
    do_write(0, 4'h7, 1'b0, 1'b1);
    do_write(1, 4'h2, 1'b0, 1'b0);
    cyc(6 * FRAME);
`endif

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
